// File: rtl/instr_encoder_loader.sv
// Packs decoded RISC-V fields into 32-bit words and streams them into instruction memory at consecutive addresses.
// Optional immediate range check: define INSTR_ENC_IMM_CHECK_EN.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_fmt,
    output logic              err_ovf,
    output logic              err_imm
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | accepting tuples and writing words
    // DONE  | session finished, done held until next start
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    state_t            state, state_nxt;
    logic              stop;
    logic              stop_ovf;
    logic              accept;
    logic              finish;
    logic              fmt_ok;
    logic              clr;
    logic              wr_done;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] tgt_addr;

    assign wr_done  = mem_we & mem_ready;
    assign clr      = (state != RUN) & start;
    // acceptance with a pending write implies that write completes this cycle
    assign tgt_addr = mem_we ? mem_addr + ADDR_W'(1) : mem_addr;

    always_comb begin
        enc_word = 32'h0;
        fmt_ok   = 1'b1;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: fmt_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                in_ready = !stop && (!mem_we || mem_ready);
                accept   = in_ready && in_valid;
                if (stop && (!mem_we || mem_ready)) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_BASE;
            mem_wdata <= 32'h0;
            done      <= 1'b0;
            count     <= '0;
            err_fmt   <= 1'b0;
            err_ovf   <= 1'b0;
            stop      <= 1'b0;
            stop_ovf  <= 1'b0;
        end else if (clr) begin
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_BASE;
            done      <= 1'b0;
            count     <= '0;
            err_fmt   <= 1'b0;
            err_ovf   <= 1'b0;
            stop      <= 1'b0;
            stop_ovf  <= 1'b0;
        end else begin
            if (wr_done) begin
                mem_we <= 1'b0;
                count  <= count + (ADDR_W+1)'(1);
                if (mem_addr != ADDR_MAX) mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (accept) begin
                if (fmt_ok) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= enc_word;
                    // the word landing on the top address closes the session unless it is last
                    if (tgt_addr == ADDR_MAX && !in_last) begin
                        stop     <= 1'b1;
                        stop_ovf <= 1'b1;
                    end
                end else begin
                    err_fmt <= 1'b1;
                end
                if (in_last) stop <= 1'b1;
            end
            if (finish) begin
                done <= 1'b1;
                if (stop_ovf) err_ovf <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_IMM_CHECK_EN
    logic imm_bad;

    always_comb begin
        imm_bad = 1'b0;
        case (in_fmt)
            3'd1, 3'd2: imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            3'd3:       imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            3'd4:       imm_bad = |in_imm[11:0];
            3'd5:       imm_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            default:    imm_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_imm <= 1'b0;
        end else if (clr) begin
            err_imm <= 1'b0;
        end else if (accept && fmt_ok && imm_bad) begin
            err_imm <= 1'b1;
        end
    end
`else
    assign err_imm = 1'b0;
`endif

endmodule
